// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder: re-times unskewed N-lane vectors into a diagonal wavefront (lane i delayed i cycles).
// Optional accepted-beat counter enabled by SKEW_FEEDER_BEAT_COUNT_EN.
module systolic_skew_feeder #(
    parameter int N  = 4,
    parameter int DW = 16
`ifdef SKEW_FEEDER_BEAT_COUNT_EN
    , parameter int CW = 16
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            abort,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_last,
    input  logic [N*DW-1:0] in_data,
    output logic [N*DW-1:0] out_data,
    output logic [N-1:0]    out_en,
    output logic            busy,
    output logic            done
`ifdef SKEW_FEEDER_BEAT_COUNT_EN
    , output logic [CW-1:0] beat_count
`endif
);
    localparam int FW = $clog2(N);
    typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;
    state_t        r_state;
    logic [FW-1:0] r_cnt;
    logic          r_done;
    logic          w_acc;
    assign in_ready = r_state != FLUSH;
    assign busy     = r_state != IDLE;
    assign done     = r_done;
    assign w_acc    = in_valid && in_ready && !abort;
    // done rises on the edge that moves the last vector onto lane N-1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else if (abort) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= r_state == FLUSH && r_cnt == FW'(1);
            if (r_state == FLUSH) begin
                r_cnt <= r_cnt - 1'b1;
                if (r_cnt == FW'(1))
                    r_state <= IDLE;
            end else if (w_acc) begin
                r_state <= in_last ? FLUSH : STREAM;
                r_cnt   <= FW'(N - 1);
            end
        end
    end
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [DW-1:0] r_d [0:i];
        logic          r_v [0:i];
        always_ff @(posedge clk or posedge rst) begin
            if (rst || abort) begin
                for (int s = 0; s <= i; s++) begin
                    r_d[s] <= '0;
                    r_v[s] <= 1'b0;
                end
            end else begin
                r_d[0] <= w_acc ? in_data[i*DW +: DW] : '0;
                r_v[0] <= w_acc;
                for (int s = 1; s <= i; s++) begin
                    r_d[s] <= r_d[s-1];
                    r_v[s] <= r_v[s-1];
                end
            end
        end
        assign out_data[i*DW +: DW] = r_d[i];
        assign out_en[i]            = r_v[i];
    end
`ifdef SKEW_FEEDER_BEAT_COUNT_EN
    logic [CW-1:0] r_beats;
    logic [CW-1:0] w_base;
    assign w_base     = r_done ? '0 : r_beats;
    assign beat_count = r_beats;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_beats <= '0;
        else if (abort)
            r_beats <= '0;
        else
            r_beats <= (w_acc && !(&w_base)) ? w_base + 1'b1 : w_base;
    end
`endif
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb_systolic_skew_feeder: scoreboard bench; per-lane expectations queued at acceptance, checked by a negedge monitor.
module tb_systolic_skew_feeder;
    localparam int N  = 4;
    localparam int DW = 16;
    localparam int W  = N * DW;
    logic clk = 0, rst = 1, abort = 0, in_valid = 0, in_last = 0;
    logic [W-1:0] in_data = '0;
    logic         in_ready, busy, done;
    logic [W-1:0] out_data;
    logic [N-1:0] out_en;
`ifdef SKEW_FEEDER_BEAT_COUNT_EN
    logic [15:0]  beat_count;
`endif
    always #5 clk = ~clk;

    systolic_skew_feeder #(.N(N), .DW(DW)) dut (
        .clk(clk), .rst(rst), .abort(abort), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .in_data(in_data), .out_data(out_data), .out_en(out_en),
        .busy(busy), .done(done)
`ifdef SKEW_FEEDER_BEAT_COUNT_EN
        , .beat_count(beat_count)
`endif
    );

    typedef struct {int due; logic [DW-1:0] d;} exp_t;
    exp_t lq [N][$];
    int   done_q[$];
    int   cyc = 0, block_until = 0, done_at = -1, bc_m = 0;
    int   errors = 0, checks = 0;
    bit   streaming = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) lq[i].delete();
        done_q.delete();
        block_until = 0;
        streaming   = 0;
        done_at     = -1;
        bc_m        = 0;
    endtask

    // Reference: a vector accepted at edge k shows on lane i during cycle k+i; done during k+N-1 after a last beat
    always @(posedge clk) begin
        bit acc;
        int cn;
        if (!rst) begin
            acc = in_valid && !abort && cyc >= block_until;
            cn  = cyc + 1;
            if (cyc == done_at) bc_m = 0;
            if (abort) clear_model();
            else if (acc) begin
                for (int i = 0; i < N; i++) lq[i].push_back('{cn + i, in_data[i*DW +: DW]});
                if (bc_m < 65535) bc_m++;
                if (in_last) begin
                    block_until = cn + N - 1;
                    done_at     = cn + N - 1;
                    done_q.push_back(done_at);
                    streaming = 0;
                end else streaming = 1;
            end
            cyc = cn;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        bit   dexp;
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                if (lq[i].size() > 0 && lq[i][0].due == cyc) begin
                    e = lq[i].pop_front();
                    chk($sformatf("lane%0d_en", i), 64'(out_en[i]), 64'd1);
                    chk($sformatf("lane%0d_data", i), 64'(out_data[i*DW +: DW]), 64'(e.d));
                end else begin
                    chk($sformatf("lane%0d_bubble_en", i), 64'(out_en[i]), 64'd0);
                    chk($sformatf("lane%0d_bubble_data", i), 64'(out_data[i*DW +: DW]), 64'd0);
                end
            end
            dexp = done_q.size() > 0 && done_q[0] == cyc;
            if (dexp) void'(done_q.pop_front());
            chk("done", 64'(done), 64'(dexp));
            chk("in_ready", 64'(in_ready), 64'(cyc >= block_until));
            chk("busy", 64'(busy), 64'(streaming || cyc < block_until));
`ifdef SKEW_FEEDER_BEAT_COUNT_EN
            chk("beat_count", 64'(beat_count), 64'(bc_m));
`endif
        end
    end

    function automatic logic [W-1:0] vec(int a, int b, int c, int d);
        logic [DW-1:0] l0 = DW'(a), l1 = DW'(b), l2 = DW'(c), l3 = DW'(d);
        return {l3, l2, l1, l0};
    endfunction

    task automatic drive(bit v, logic [W-1:0] d, bit l, bit a);
        in_valid = v; in_data = d; in_last = l; abort = a;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        repeat (n) drive(0, '0, 0, 0);
    endtask

    task automatic pass_abc();
        drive(1, vec(1, 2, 3, 4), 0, 0);
        drive(1, vec(5, 6, 7, 8), 0, 0);
        drive(1, vec(9, 10, 11, 12), 1, 0);
    endtask

    initial begin
        @(posedge clk);
        #1;
        chk("rst_out_en", 64'(out_en), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        rst = 0;
        idle(2);
        pass_abc();
        idle(N + 2);
        drive(1, vec(17, 18, 19, 20), 0, 0);
        idle(1);
        drive(1, vec(33, 34, 35, 36), 1, 0);
        idle(N + 2);
        for (int k = 0; k < 8; k++) drive(1, vec(k, k + 64, k + 128, k + 192), 1, 0);
        idle(N + 2);
        drive(1, vec(41, 42, 43, 44), 0, 0);
        drive(1, vec(45, 46, 47, 48), 0, 0);
        drive(1, vec(49, 50, 51, 52), 0, 1);
        pass_abc();
        idle(N + 2);
        drive(1, vec(3, 3, 3, 3), 0, 0);
        drive(1, vec(4, 4, 4, 4), 0, 0);
        drive(1, vec(5, 5, 5, 5), 0, 0);
        drive(1, vec(6, 6, 6, 6), 0, 0);
        drive(1, vec(7, 7, 7, 7), 1, 0);
        idle(N + 2);
        repeat (3000)
            drive($urandom_range(0, 3) != 0, {$urandom(), $urandom()},
                  $urandom_range(0, 4) == 0, $urandom_range(0, 39) == 0);
        idle(N + 3);
        chk("drain_empty", 64'(lq[0].size() + lq[1].size() + lq[2].size() + lq[3].size() + done_q.size()), 64'd0);
        drive(1, vec(90, 91, 92, 93), 0, 0);
        drive(1, vec(94, 95, 96, 97), 1, 0);
        idle(1);
        #1 rst = 1;
        #1;
        chk("async_rst_out_en", 64'(out_en), 64'd0);
        chk("async_rst_out_data", 64'(out_data), 64'd0);
        chk("async_rst_busy", 64'(busy), 64'd0);
        chk("async_rst_done", 64'(done), 64'd0);
        clear_model();
        #1 rst = 0;
        #1;
        chk("post_rst_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        idle(1);
        pass_abc();
        idle(N + 2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
